universal_shifter: RTL and testbench

UNIVERSAL_SHIFTER -- requirements
Module: universal_shifter

---
 rtl/shifter_pkg.sv | 18 +
 rtl/shifter_stage.sv | 69 ++++++
 rtl/universal_shifter.sv | 129 ++++++++++++
 tb/tb_universal_shifter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared mode encodings and per-slot select codes for the universal shifter
package shifter_pkg;

  // Operating mode encodings carried on the mode port
  localparam logic [1:0] MODE_HOLD        = 2'd0;
  localparam logic [1:0] MODE_SHIFT_DOWN  = 2'd1;
  localparam logic [1:0] MODE_SHIFT_UP    = 2'd2;
  localparam logic [1:0] MODE_ROTATE_DOWN = 2'd3;

  // Next-value source for a single slot
  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_LOAD = 2'd1,
    SEL_DOWN = 2'd2,  // take the neighbour above (slot i+1)
    SEL_UP   = 2'd3   // take the neighbour below (slot i-1)
  } sel_e;

endpackage

// File: rtl/shifter_stage.sv
// rtl/shifter_stage.sv - one shifter slot: data register plus valid tag with a 4-way next-value mux
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_i,
  input  sel_e             sel_i,
  input  logic [width-1:0] load_data_i,
  input  logic [width-1:0] down_data_i,
  input  logic             down_valid_i,
  input  logic [width-1:0] up_data_i,
  input  logic             up_valid_i,
  output logic [width-1:0] data_o,
  output logic             valid_o
);

  logic [width-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Select the next slot value; clear drops the tag but leaves data in place
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    case (sel_i)
      SEL_HOLD: begin
        data_d  = data_q;
        valid_d = valid_q;
      end
      SEL_LOAD: begin
        data_d  = load_data_i;
        valid_d = 1'b1;
      end
      SEL_DOWN: begin
        data_d  = down_data_i;
        valid_d = down_valid_i;
      end
      SEL_UP: begin
        data_d  = up_data_i;
        valid_d = up_valid_i;
      end
      default: begin
        data_d  = data_q;
        valid_d = valid_q;
      end
    endcase
    if (clear_i) begin
      data_d  = data_q;
      valid_d = 1'b0;
    end
  end

  // Slot register with immediate reset to empty
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/universal_shifter.sv
// rtl/universal_shifter.sv - multi-slot shift/rotate/load register with valid tags and occupancy count
module universal_shifter
  import shifter_pkg::*;
#(
  parameter int count = 4,
  parameter int width = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       load,
  input  logic [1:0]                 mode,
  input  logic [count*width-1:0]     parallel_in,
  input  logic [width-1:0]           serial_in,
  input  logic                       serial_in_valid,
  output logic [count*width-1:0]     parallel_out,
  output logic [count-1:0]           valid_out,
  output logic [width-1:0]           serial_out,
  output logic                       serial_out_valid,
  output logic [width-1:0]           serial_out_hi,
  output logic                       serial_out_hi_valid,
  output logic [$clog2(count+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(count + 1);

  sel_e             sel;
  logic             rotate;
  logic [width-1:0] top_data;
  logic             top_valid;
  logic [width-1:0] slot_data [count];
  logic [count-1:0] slot_valid;
  logic [OCC_W-1:0] occ_q, occ_d;

  // Priority decode: clear beats load, load beats mode, enable gates both
  always_comb begin
    sel = SEL_HOLD;
    if (!clear && enable) begin
      if (load) begin
        sel = SEL_LOAD;
      end else begin
        case (mode)
          MODE_SHIFT_DOWN:  sel = SEL_DOWN;
          MODE_ROTATE_DOWN: sel = SEL_DOWN;
          MODE_SHIFT_UP:    sel = SEL_UP;
          default:          sel = SEL_HOLD;
        endcase
      end
    end
  end

  // Rotation is a down-shift whose top slot is fed from slot 0 instead of serial_in
  assign rotate    = (mode == MODE_ROTATE_DOWN);
  assign top_data  = rotate ? slot_data[0]  : serial_in;
  assign top_valid = rotate ? slot_valid[0] : serial_in_valid;

  for (genvar g = 0; g < count; g++) begin : g_slot
    logic [width-1:0] dn_data, up_data;
    logic             dn_valid, up_valid;

    if (g == count - 1) begin : g_top
      assign dn_data  = top_data;
      assign dn_valid = top_valid;
    end else begin : g_mid_dn
      assign dn_data  = slot_data[g+1];
      assign dn_valid = slot_valid[g+1];
    end

    if (g == 0) begin : g_bot
      assign up_data  = serial_in;
      assign up_valid = serial_in_valid;
    end else begin : g_mid_up
      assign up_data  = slot_data[g-1];
      assign up_valid = slot_valid[g-1];
    end

    shifter_stage #(.width(width)) u_stage (
      .clock        (clock),
      .reset_n      (reset_n),
      .clear_i      (clear),
      .sel_i        (sel),
      .load_data_i  (parallel_in[g*width +: width]),
      .down_data_i  (dn_data),
      .down_valid_i (dn_valid),
      .up_data_i    (up_data),
      .up_valid_i   (up_valid),
      .data_o       (slot_data[g]),
      .valid_o      (slot_valid[g])
    );

    assign parallel_out[g*width +: width] = slot_data[g];
  end

  // Occupancy tracks the tag entering versus the tag leaving on each shift
  always_comb begin
    occ_d = occ_q;
    if (clear) begin
      occ_d = '0;
    end else if (enable) begin
      if (load) begin
        occ_d = OCC_W'(count);
      end else if (mode == MODE_SHIFT_DOWN || mode == MODE_SHIFT_UP) begin
        if (serial_in_valid && !((mode == MODE_SHIFT_DOWN) ? slot_valid[0] : slot_valid[count-1])) begin
          occ_d = occ_q + OCC_W'(1);
        end else if (!serial_in_valid && ((mode == MODE_SHIFT_DOWN) ? slot_valid[0] : slot_valid[count-1])) begin
          occ_d = occ_q - OCC_W'(1);
        end
      end
    end
  end

  // Occupancy register, emptied immediately on reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign valid_out           = slot_valid;
  assign serial_out          = slot_data[0];
  assign serial_out_valid    = slot_valid[0];
  assign serial_out_hi       = slot_data[count-1];
  assign serial_out_hi_valid = slot_valid[count-1];
  assign occupancy           = occ_q;

endmodule

// File: tb/tb_universal_shifter.sv
// tb/tb_universal_shifter.sv - randomized and directed self-checking bench for universal_shifter
module tb_universal_shifter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] parallel_in = '0;
  logic [7:0]  serial_in = '0;
  logic        serial_in_valid = 1'b0;
  logic [31:0] parallel_out;
  logic [3:0]  valid_out;
  logic [7:0]  serial_out;
  logic        serial_out_valid;
  logic [7:0]  serial_out_hi;
  logic        serial_out_hi_valid;
  logic [2:0]  occupancy;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Reference model: slot 0 is the front of each queue
  int unsigned m_data[$];
  bit          m_valid[$];

  universal_shifter #(.count(4), .width(8)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .enable              (enable),
    .clear               (clear),
    .load                (load),
    .mode                (mode),
    .parallel_in         (parallel_in),
    .serial_in           (serial_in),
    .serial_in_valid     (serial_in_valid),
    .parallel_out        (parallel_out),
    .valid_out           (valid_out),
    .serial_out          (serial_out),
    .serial_out_valid    (serial_out_valid),
    .serial_out_hi       (serial_out_hi),
    .serial_out_hi_valid (serial_out_hi_valid),
    .occupancy           (occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data.delete();
    m_valid.delete();
    repeat (4) begin
      m_data.push_back(0);
      m_valid.push_back(1'b0);
    end
  endtask

  initial model_reset();

  // Behavioural model: queue operations applied at each rising edge
  always @(posedge clock or negedge reset_n) begin
    int unsigned d;
    bit          v;
    if (!reset_n) begin
      model_reset();
    end else if (clear) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
    end else if (enable) begin
      if (load) begin
        foreach (m_data[i]) begin
          m_data[i]  = parallel_in[i*8 +: 8];
          m_valid[i] = 1'b1;
        end
      end else begin
        case (mode)
          2'd1: begin
            d = m_data.pop_front();  v = m_valid.pop_front();
            m_data.push_back(serial_in); m_valid.push_back(serial_in_valid);
          end
          2'd2: begin
            d = m_data.pop_back();  v = m_valid.pop_back();
            m_data.push_front(serial_in); m_valid.push_front(serial_in_valid);
          end
          2'd3: begin
            d = m_data.pop_front();  v = m_valid.pop_front();
            m_data.push_back(d); m_valid.push_back(v);
          end
          default: ;
        endcase
      end
    end
  end

  // Compare process: every output against the model on each falling edge
  always @(negedge clock) begin
    logic [31:0] exp_po;
    logic [3:0]  exp_v;
    int          pop;
    if (check_en) begin
      pop = 0;
      for (int i = 0; i < 4; i++) begin
        exp_po[i*8 +: 8] = m_data[i][7:0];
        exp_v[i]         = m_valid[i];
        pop += int'(m_valid[i]);
      end
      chk("parallel_out", parallel_out, exp_po);
      chk("valid_out", {28'd0, valid_out}, {28'd0, exp_v});
      chk("serial_out", {24'd0, serial_out}, {24'd0, exp_po[7:0]});
      chk("serial_out_valid", {31'd0, serial_out_valid}, {31'd0, exp_v[0]});
      chk("serial_out_hi", {24'd0, serial_out_hi}, {24'd0, exp_po[31:24]});
      chk("serial_out_hi_valid", {31'd0, serial_out_hi_valid}, {31'd0, exp_v[3]});
      chk("occupancy", {29'd0, occupancy}, 32'(pop));
      chk("occupancy_popcount", {29'd0, occupancy}, 32'($countones(valid_out)));
    end
  end

  task automatic step(input logic c, input logic e, input logic l, input logic [1:0] m,
                      input logic [31:0] p, input logic [7:0] s, input logic sv);
    @(negedge clock);
    clear = c; enable = e; load = l; mode = m;
    parallel_in = p; serial_in = s; serial_in_valid = sv;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] exp_so [4];
    logic [2:0] exp_occ [4];
    exp_so[0] = 8'h22; exp_so[1] = 8'h33; exp_so[2] = 8'h44; exp_so[3] = 8'hAA;
    exp_occ[0] = 3'd3; exp_occ[1] = 3'd2; exp_occ[2] = 3'd1; exp_occ[3] = 3'd0;

    repeat (2) @(negedge clock);
    chk("reset_parallel_out", parallel_out, 32'h0);
    chk("reset_valid_out", {28'd0, valid_out}, 32'h0);
    chk("reset_occupancy", {29'd0, occupancy}, 32'h0);
    reset_n = 1'b1;
    check_en = 1'b1;

    // Parallel load
    step(0, 1, 1, 2'd0, 32'h44332211, 8'h00, 0);
    chk("load_po", parallel_out, 32'h44332211);
    chk("load_valid", {28'd0, valid_out}, 32'hF);
    chk("load_occ", {29'd0, occupancy}, 32'd4);
    chk("load_so", {24'd0, serial_out}, 32'h11);

    // Four shift-downs of an invalid 0xAA
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 2'd1, 32'h0, 8'hAA, 0);
      chk("shdn_so", {24'd0, serial_out}, {24'd0, exp_so[k]});
      chk("shdn_occ", {29'd0, occupancy}, {29'd0, exp_occ[k]});
    end

    // Shift up of a valid 0x55
    step(0, 1, 1, 2'd0, 32'h44332211, 8'h00, 0);
    step(0, 1, 0, 2'd2, 32'h0, 8'h55, 1);
    chk("shup_po", parallel_out, 32'h33221155);
    chk("shup_hi", {24'd0, serial_out_hi}, 32'h33);
    chk("shup_occ", {29'd0, occupancy}, 32'd4);

    // Rotate four times back to the original
    step(0, 1, 1, 2'd0, 32'h44332211, 8'h00, 0);
    step(0, 1, 0, 2'd3, 32'h0, 8'hEE, 0);
    chk("rot1_po", parallel_out, 32'h11443322);
    chk("rot_valid", {28'd0, valid_out}, 32'hF);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 2'd3, 32'h0, 8'hEE, 0);
      chk("rot_valid", {28'd0, valid_out}, 32'hF);
    end
    chk("rot4_po", parallel_out, 32'h44332211);

    // Clear wins over load and shift even with enable low
    step(1, 0, 1, 2'd1, 32'hDEADBEEF, 8'h99, 1);
    chk("clr_valid", {28'd0, valid_out}, 32'h0);
    chk("clr_occ", {29'd0, occupancy}, 32'h0);
    chk("clr_po", parallel_out, 32'h44332211);

    // Enable low holds everything
    step(0, 1, 1, 2'd0, 32'h87654321, 8'h00, 0);
    step(0, 0, 1, 2'd1, 32'h11111111, 8'h77, 1);
    chk("hold_po", parallel_out, 32'h87654321);
    chk("hold_occ", {29'd0, occupancy}, 32'd4);

    // Reset asserted between edges in the middle of a shift
    @(negedge clock);
    clear = 0; enable = 1; load = 0; mode = 2'd1; serial_in = 8'h5A; serial_in_valid = 1;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_po", parallel_out, 32'h0);
    chk("async_rst_valid", {28'd0, valid_out}, 32'h0);
    chk("async_rst_occ", {29'd0, occupancy}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Randomized stress
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      clear           = ($urandom_range(0, 15) == 0);
      enable          = ($urandom_range(0, 7) != 0);
      load            = ($urandom_range(0, 9) == 0);
      mode            = 2'($urandom_range(0, 3));
      parallel_in     = $urandom;
      serial_in       = 8'($urandom_range(0, 255));
      serial_in_valid = 1'($urandom_range(0, 1));
      if (c % 150 == 75) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rand_rst_po", parallel_out, 32'h0);
        chk("rand_rst_occ", {29'd0, occupancy}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
      end
    end

    @(negedge clock);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
